// File: rtl/instructions_pkg.sv
// Shared instruction-level constants: write-back source select and load funct3 codes.
package instructions_pkg;

  // Register-file write-back source; 2'b11 is decoded as ALU by consumers.
  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_PC4  = 2'b01,
    WB_LOAD = 2'b10
  } wb_sel_e;

  // Load funct3 encodings (RV32I).
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load-data extract and sign/zero extension.
// Byte loads pick byte[lsb]; halfword loads pick half[lsb[1]] (lsb[0] ignored);
// LW and any unsupported funct3 pass the raw word through.
module wb_load_align
  import instructions_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] load_data,
  input  logic [1:0]      load_addr_lsb,
  input  logic [2:0]      load_funct3,
  output logic [XLEN-1:0] load_result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte and halfword from the aligned word.
  always_comb begin
    byte_sel = load_data[7:0];
    case (load_addr_lsb)
      2'd0:    byte_sel = load_data[7:0];
      2'd1:    byte_sel = load_data[15:8];
      2'd2:    byte_sel = load_data[23:16];
      default: byte_sel = load_data[31:24];
    endcase
    half_sel = load_addr_lsb[1] ? load_data[31:16] : load_data[15:0];
  end

  // Extend the selected field according to the load type.
  always_comb begin
    load_result = load_data;
    case (load_funct3)
      F3_LB:   load_result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  load_result = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   load_result = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  load_result = {{(XLEN-16){1'b0}}, half_sel};
      default: load_result = load_data;
    endcase
  end

endmodule

// File: rtl/wb_arbiter_stage.sv
// Registered write-back stage: arbitrates the in-order main pipe against one
// long-latency result channel (LQ) for the single register-file write port.
// The LQ is refused at most MAX_WAIT cycles before it preempts the main pipe.
// Optional feature macro: WB_RETIRE_CNT_EN adds a 64-bit retired-instruction counter.
module wb_arbiter_stage
  import instructions_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       alu_data,
  input  logic [XLEN-1:0]       pc_pls4,
  input  logic [XLEN-1:0]       load_data,
  input  logic [1:0]            load_addr_lsb,
  input  logic [2:0]            load_funct3,
  input  logic [1:0]            wb_sel,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  ctrl_reg_wr,
  input  logic                  lq_valid,
  output logic                  lq_ready,
  input  logic [XLEN-1:0]       lq_data,
  input  logic [REG_ADDR_W-1:0] lq_rd,
  output logic [XLEN-1:0]       rdData,
  output logic [REG_ADDR_W-1:0] rdOut,
  output logic                  writeEn
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]           retire_cnt
`endif
);

  // Keep the counter at least one bit wide so MAX_WAIT=0 still elaborates.
  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic [XLEN-1:0]       rd_data_q, rd_data_d;
  logic [REG_ADDR_W-1:0] rd_out_q, rd_out_d;
  logic                  write_en_q, write_en_d;

  logic                  main_wr;
  logic                  force_lq;
  logic                  main_grant;
  logic                  lq_grant;
  logic [XLEN-1:0]       load_result;
  logic [XLEN-1:0]       main_data;

  wb_load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .load_data    (load_data),
    .load_addr_lsb(load_addr_lsb),
    .load_funct3  (load_funct3),
    .load_result  (load_result)
  );

  // Main-pipe write data source select; 2'b11 falls back to ALU.
  always_comb begin
    main_data = alu_data;
    case (wb_sel)
      WB_PC4:  main_data = pc_pls4;
      WB_LOAD: main_data = load_result;
      default: main_data = alu_data;
    endcase
  end

  // Arbitration: a starved LQ preempts; otherwise a real main write wins;
  // a main instruction without a write never blocks the LQ.
  always_comb begin
    main_wr    = in_valid & ctrl_reg_wr & (rd != '0);
    force_lq   = lq_valid & (wait_cnt_q >= WAIT_LIMIT);
    in_ready   = ~force_lq;
    lq_ready   = lq_valid & (force_lq | ~main_wr);
    lq_grant   = lq_ready;
    main_grant = main_wr & ~force_lq;
  end

  // Next-state for the output flops and the starvation counter.
  always_comb begin
    write_en_d = 1'b0;
    rd_out_d   = rd_out_q;
    rd_data_d  = rd_data_q;
    if (main_grant) begin
      write_en_d = 1'b1;
      rd_out_d   = rd;
      rd_data_d  = main_data;
    end else if (lq_grant) begin
      write_en_d = (lq_rd != '0);
      rd_out_d   = lq_rd;
      rd_data_d  = lq_data;
    end

    wait_cnt_d = wait_cnt_q;
    if (!lq_valid || lq_ready) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < WAIT_LIMIT) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      write_en_q <= 1'b0;
      rd_out_q   <= '0;
      rd_data_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      write_en_q <= write_en_d;
      rd_out_q   <= rd_out_d;
      rd_data_q  <= rd_data_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign writeEn = write_en_q;
  assign rdOut   = rd_out_q;
  assign rdData  = rd_data_q;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_q, retire_cnt_d;

  // Count every accepted main-pipe instruction, writing or not; wraps at 2^64.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (in_valid && in_ready) begin
      retire_cnt_d = retire_cnt_q + 64'd1;
    end
  end

  // Retire counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_arbiter_stage.sv
// Directed bench for wb_arbiter_stage: a vector table of single-cycle
// transactions plus hand-written starvation, reset and retire sequences.
module tb_wb_arbiter_stage;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_data;
  logic [31:0] pc_pls4;
  logic [31:0] load_data;
  logic [1:0]  load_addr_lsb;
  logic [2:0]  load_funct3;
  logic [1:0]  wb_sel;
  logic [4:0]  rd;
  logic        ctrl_reg_wr;
  logic        lq_valid;
  logic        lq_ready;
  logic [31:0] lq_data;
  logic [4:0]  lq_rd;
  logic [31:0] rdData;
  logic [4:0]  rdOut;
  logic        writeEn;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  int errors = 0;
  int checks = 0;

  wb_arbiter_stage #(
    .XLEN(32),
    .REG_ADDR_W(5),
    .MAX_WAIT(4)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_data     (alu_data),
    .pc_pls4      (pc_pls4),
    .load_data    (load_data),
    .load_addr_lsb(load_addr_lsb),
    .load_funct3  (load_funct3),
    .wb_sel       (wb_sel),
    .rd           (rd),
    .ctrl_reg_wr  (ctrl_reg_wr),
    .lq_valid     (lq_valid),
    .lq_ready     (lq_ready),
    .lq_data      (lq_data),
    .lq_rd        (lq_rd),
    .rdData       (rdData),
    .rdOut        (rdOut),
    .writeEn      (writeEn)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt   (retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        cw;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] ld;
    logic [1:0]  lsb;
    logic [2:0]  f3;
    logic [4:0]  rdi;
    logic        lv;
    logic [31:0] lqd;
    logic [4:0]  lqrd;
    logic        e_ir;
    logic        e_lr;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_dat;
    logic        chk_dat;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; ctrl_reg_wr = 1'b0; wb_sel = 2'b00; alu_data = '0; pc_pls4 = '0;
    load_data = '0; load_addr_lsb = '0; load_funct3 = '0; rd = '0;
    lq_valid = 1'b0; lq_data = '0; lq_rd = '0;
  endtask

  // Main pipe writes rd=1 every cycle while the LQ holds a result for lq_rd=9.
  // The LQ must be refused four cycles and granted on the fifth.
  task automatic run_starve(input string tag);
    in_valid = 1'b1; ctrl_reg_wr = 1'b1; wb_sel = 2'b00; alu_data = 32'h0000_00A1; rd = 5'd1;
    lq_valid = 1'b1; lq_data = 32'h0000_0099; lq_rd = 5'd9;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("%s lq_ready c%0d", tag, k), {63'd0, lq_ready}, {63'd0, (k == 4)});
      check($sformatf("%s in_ready c%0d", tag, k), {63'd0, in_ready}, {63'd0, (k != 4)});
      @(posedge clk); #1;
      check($sformatf("%s writeEn c%0d", tag, k), {63'd0, writeEn}, 64'd1);
      check($sformatf("%s rdOut c%0d", tag, k), {59'd0, rdOut}, (k == 4) ? 64'd9 : 64'd1);
    end
    check({tag, " lq data"}, {32'd0, rdData}, 64'h99);
    lq_valid = 1'b0;
    @(negedge clk);
    check({tag, " in_ready resume"}, {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    check({tag, " main resume rdOut"}, {59'd0, rdOut}, 64'd1);
    $display("txn %s: starvation grant on 5th cycle sequence done", tag);
    idle_inputs();
  endtask

  initial begin
    // iv cw sel alu pc4 ld lsb f3 rd lv lqd lqrd | e_ir e_lr e_we e_rd e_dat chk
    vecs[0]  = '{1'b1, 1'b1, 2'b10, 32'h0, 32'h0, 32'h80FF_7F01, 2'd3, 3'd0, 5'd5,  1'b0, 32'h0, 5'd0,
                 1'b1, 1'b0, 1'b1, 5'd5,  32'hFFFF_FF80, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 2'b10, 32'h0, 32'h0, 32'h80FF_7F01, 2'd2, 3'd5, 5'd6,  1'b0, 32'h0, 5'd0,
                 1'b1, 1'b0, 1'b1, 5'd6,  32'h0000_80FF, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 2'b01, 32'h0, 32'h104, 32'h0, 2'd0, 3'd0, 5'd7,   1'b0, 32'h0, 5'd0,
                 1'b1, 1'b0, 1'b1, 5'd7,  32'h0000_0104, 1'b1};
    vecs[3]  = '{1'b1, 1'b1, 2'b10, 32'h0, 32'h0, 32'h80FF_7F01, 2'd0, 3'd0, 5'd8,  1'b0, 32'h0, 5'd0,
                 1'b1, 1'b0, 1'b1, 5'd8,  32'h0000_0001, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 2'b10, 32'h0, 32'h0, 32'h80FF_7F01, 2'd3, 3'd4, 5'd9,  1'b0, 32'h0, 5'd0,
                 1'b1, 1'b0, 1'b1, 5'd9,  32'h0000_0080, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 2'b10, 32'h0, 32'h0, 32'h80FF_7F01, 2'd3, 3'd1, 5'd10, 1'b0, 32'h0, 5'd0,
                 1'b1, 1'b0, 1'b1, 5'd10, 32'hFFFF_80FF, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 2'b10, 32'h0, 32'h0, 32'h80FF_7F01, 2'd2, 3'd2, 5'd11, 1'b0, 32'h0, 5'd0,
                 1'b1, 1'b0, 1'b1, 5'd11, 32'h80FF_7F01, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 2'b10, 32'h0, 32'h0, 32'h80FF_7F01, 2'd1, 3'd3, 5'd12, 1'b0, 32'h0, 5'd0,
                 1'b1, 1'b0, 1'b1, 5'd12, 32'h80FF_7F01, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 2'b11, 32'hDEAD_BEEF, 32'h0, 32'h0, 2'd0, 3'd0, 5'd13, 1'b0, 32'h0, 5'd0,
                 1'b1, 1'b0, 1'b1, 5'd13, 32'hDEAD_BEEF, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 2'b00, 32'h1234_5678, 32'h0, 32'h0, 2'd0, 3'd0, 5'd14, 1'b1, 32'h3333, 5'd3,
                 1'b1, 1'b0, 1'b1, 5'd14, 32'h1234_5678, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 2'b00, 32'h5555, 32'h0, 32'h0, 2'd0, 3'd0, 5'd15, 1'b1, 32'hCAFE_F00D, 5'd20,
                 1'b1, 1'b1, 1'b1, 5'd20, 32'hCAFE_F00D, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 2'b00, 32'h111, 32'h0, 32'h0, 2'd0, 3'd0, 5'd0, 1'b1, 32'h0BAD_F00D, 5'd21,
                 1'b1, 1'b1, 1'b1, 5'd21, 32'h0BAD_F00D, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 2'b00, 32'h222, 32'h0, 32'h0, 2'd0, 3'd0, 5'd0, 1'b0, 32'h0, 5'd0,
                 1'b1, 1'b0, 1'b0, 5'd21, 32'h0BAD_F00D, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 2'd0, 3'd0, 5'd0, 1'b1, 32'h0000_0055, 5'd0,
                 1'b1, 1'b1, 1'b0, 5'd0, 32'h0000_0055, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 2'd0, 3'd0, 5'd0, 1'b0, 32'h0, 5'd0,
                 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_0055, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 2'd0, 3'd0, 5'd0, 1'b1, 32'h0000_0077, 5'd22,
                 1'b1, 1'b1, 1'b1, 5'd22, 32'h0000_0077, 1'b1};

    // Reset state.
    idle_inputs();
    rstn = 1'b0;
    #12;
    check("reset writeEn", {63'd0, writeEn}, 64'd0);
    check("reset rdOut", {59'd0, rdOut}, 64'd0);
    check("reset rdData", {32'd0, rdData}, 64'd0);
`ifdef WB_RETIRE_CNT_EN
    check("reset retire_cnt", retire_cnt, 64'd0);
`endif
    @(posedge clk); #1;
    rstn = 1'b1;

    // Table-driven single-cycle transactions, each followed by an idle cycle
    // that clears the wait counter and ends the writeEn pulse.
    for (int i = 0; i < NV; i++) begin
      in_valid = vecs[i].iv; ctrl_reg_wr = vecs[i].cw; wb_sel = vecs[i].sel;
      alu_data = vecs[i].alu; pc_pls4 = vecs[i].pc4; load_data = vecs[i].ld;
      load_addr_lsb = vecs[i].lsb; load_funct3 = vecs[i].f3; rd = vecs[i].rdi;
      lq_valid = vecs[i].lv; lq_data = vecs[i].lqd; lq_rd = vecs[i].lqrd;
      @(negedge clk);
      check($sformatf("v%0d in_ready", i), {63'd0, in_ready}, {63'd0, vecs[i].e_ir});
      check($sformatf("v%0d lq_ready", i), {63'd0, lq_ready}, {63'd0, vecs[i].e_lr});
      @(posedge clk); #1;
      check($sformatf("v%0d writeEn", i), {63'd0, writeEn}, {63'd0, vecs[i].e_we});
      if (vecs[i].chk_dat) begin
        check($sformatf("v%0d rdOut", i), {59'd0, rdOut}, {59'd0, vecs[i].e_rd});
        check($sformatf("v%0d rdData", i), {32'd0, rdData}, {32'd0, vecs[i].e_dat});
      end
      $display("txn v%0d: we=%0b rd=%0d data=%08h", i, writeEn, rdOut, rdData);
      idle_inputs();
      @(posedge clk); #1;
      check($sformatf("v%0d pulse end", i), {63'd0, writeEn}, 64'd0);
    end

    // LQ starvation limit.
    run_starve("starve");

    // Reset asserted mid-stall after three refusals.
    in_valid = 1'b1; ctrl_reg_wr = 1'b1; wb_sel = 2'b00; alu_data = 32'h22; rd = 5'd2;
    lq_valid = 1'b1; lq_data = 32'h99; lq_rd = 5'd9;
    repeat (3) @(posedge clk);
    #2;
    check("pre-reset writeEn", {63'd0, writeEn}, 64'd1);
    rstn = 1'b0;
    #1;
    check("async reset writeEn", {63'd0, writeEn}, 64'd0);
    check("async reset rdOut", {59'd0, rdOut}, 64'd0);
    check("async reset rdData", {32'd0, rdData}, 64'd0);
    @(posedge clk); #1;
    check("held reset writeEn", {63'd0, writeEn}, 64'd0);
    rstn = 1'b1;
    $display("txn reset: async reset mid-stall applied and released");
    run_starve("post-reset");

`ifdef WB_RETIRE_CNT_EN
    rstn = 1'b0;
    #1;
    check("retire reset", retire_cnt, 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; ctrl_reg_wr = i[0]; rd = 5'(i + 1); alu_data = 32'(i);
      @(posedge clk); #1;
    end
    idle_inputs();
    @(posedge clk); #1;
    check("retire count 10", retire_cnt, 64'd10);
    $display("txn retire: retire_cnt=%0d", retire_cnt);
    rstn = 1'b0;
    #1;
    check("retire cleared", retire_cnt, 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
